gmux_qen_ctrl: RTL and testbench
================================

# gmux_qen_ctrl

Sequencer that drives the per-quadrant enable controls of a global high-speed clock mux: SSEL and, for each of the four quadrants TL/TR/BL/BR, the DEN/DYNEN/SEN/VLP signals. Each quadrant is moved between off, low-power and clock-on states in a fixed, glitch-safe order, with settle delays between steps. Software/fabric requests a quadrant on or off with a level-based request/acknowledge handshake. The block sits on the control side of the global clock network, in fabric logic beside the clock mux cell.

## Interface
- SETTLE_CYCLES, 4: cycles spent in each settle step; legal range 1..255.
- VLP_DELAY, 16: cycles after a quadrant is disabled before its VLP is asserted; legal range 1..255.

- QCK  in  1  block clock, rising edge.
- QRT_N  in  1  reset; one clock, synchronous, active-low.
- REQ_EN  in  4  requested quadrant state, level; bit0 TL, bit1 TR, bit2 BL, bit3 BR.
- MODE_DYN  in  1  1 = dynamic enable path (DYNEN+DEN), 0 = static (SEN); sampled when an enable is accepted.
- ACK  out  4  granted quadrant state, same bit order; equals REQ_EN when all requests are serviced.
- BUSY  out  1  1 while FSM is outside IDLE.
- SSEL  out  1  1 while any quadrant has SEN or DYNEN set.
- TL_DEN, TL_DYNEN, TL_SEN, TL_VLP  out  1 each  TL quadrant controls; TR_*, BL_*, BR_* likewise (16 outputs).

## Operation
- Reset (QRT_N=0 at an edge): all DEN/DYNEN/SEN=0, all VLP=1, ACK=0, BUSY=0, SSEL=0, FSM=IDLE, scan pointer p=0, counter=0, latched mode=0. This applies mid-sequence too; no step completes.
- One shared FSM services one quadrant at a time. Mismatch on quadrant i: REQ_EN[i] != ACK[i].
- IDLE: if mismatch at p, latch q=p and direction. Enable goes to WAKE; disable goes to DROP. Otherwise p <= p+1 (mod 4).
- WAKE (enable): entered with VLP[q]<=0 and cnt<=SETTLE_CYCLES-1. When cnt==0, go to ARM; otherwise decrement.
- ARM: entered with latched mode = MODE_DYN. Set DYNEN[q]<=1 if dynamic, else SEN[q]<=1, and cnt<=SETTLE_CYCLES-1. When cnt==0, go to IDLE with DEN[q]<=1 (dynamic only), ACK[q]<=1, p<=q+1.
- DROP (disable): entered with DEN[q]<=0 and cnt<=SETTLE_CYCLES-1. When cnt==0, go to SLEEP with SEN[q]<=0, DYNEN[q]<=0, ACK[q]<=0, cnt<=VLP_DELAY-1.
- SLEEP: if REQ_EN[q]==1, abort: go to IDLE with VLP[q] left 0 and p<=q. The re-enable is serviced next. Else when cnt==0, go to IDLE with VLP[q]<=1 and p<=q+1.
- Request changes during WAKE/ARM/DROP are ignored until the sequence ends; the resulting mismatch is serviced in a later IDLE scan.
- Invariants, never violated:
  - DEN[i]=1 implies DYNEN[i]=1.
  - SEN and DYNEN are never both 1 for the same quadrant.
  - VLP[i]=1 implies SEN=DYNEN=DEN=0 for that quadrant.
- SSEL is registered: SSEL <= OR over quadrants of (SEN|DYNEN) as of the next-state values.
- Counter is 8 bits; parameters outside 1..255 are illegal (elaboration assertion).

## Timing
- Let e0 be the edge leaving IDLE; N = SETTLE_CYCLES, M = VLP_DELAY.
- Enable:
  - VLP[q] falls at e0.
  - SEN/DYNEN rises at e0+N.
  - DEN and ACK[q] rise at e0+2N.
  - BUSY is high from e0 to e0+2N.
- Disable:
  - DEN falls at e0.
  - SEN/DYNEN and ACK[q] fall at e0+N.
  - VLP rises and BUSY falls at e0+N+M.
- Detection latency: 1 cycle if p==i, up to 4 cycles otherwise (scan advances 1 per idle cycle).
- Back-to-back: a new service may leave IDLE one cycle after the previous one returns to IDLE.
- SSEL rises on the same edge as the first SEN/DYNEN and falls on the same edge as the last one clears.

## Test plan
- Reset: hold QRT_N=0 for 2 cycles, then release -> all VLP=1, all other outputs 0, BUSY=0.
- Dynamic enable TL (N=4, MODE_DYN=1, REQ_EN=0001 with p=0):
  - TL_VLP=0 at e0.
  - TL_DYNEN=1 and SSEL=1 at e0+4.
  - TL_DEN=1 and ACK=0001 at e0+8.
  - TL_SEN stays 0 throughout.
- Static disable BR after enable (M=16, REQ_EN 1000->0000):
  - BR_SEN=0, ACK=0000 and SSEL=0 at e0+4.
  - BR_VLP=1 at e0+20.
- Abort: disable TR, then re-raise REQ_EN[1] 3 cycles into SLEEP -> TR_VLP never rises; TR is re-enabled and ACK[1]=1 within 1+2N cycles.
- Simultaneous requests: REQ_EN 0000->1111 in one cycle -> quadrants serviced in order TL, TR, BL, BR; ACK bits set at 8-cycle spacing plus 1 IDLE cycle each; invariants hold every cycle.
- Reset mid-ARM: assert QRT_N=0 during ARM of BL -> next edge all outputs at reset values; after release, REQ_EN=0100 restarts BL from WAKE.

Source files
------------

// File: rtl/gmux_qen_ctrl.sv
// gmux_qen_ctrl
// Sequences the per-quadrant enables of a global clock mux (TL/TR/BL/BR).
// One shared FSM walks one quadrant at a time through a fixed order.
//   enable : VLP low -> settle -> SEN or DYNEN high -> settle -> DEN (dyn) + ACK
//   disable: DEN low -> settle -> SEN/DYNEN/ACK low -> VLP delay -> VLP high
// Ports:
//   QCK        block clock, rising edge
//   QRT_N      synchronous active-low reset
//   REQ_EN[3:0] requested quadrant state (bit0 TL, bit1 TR, bit2 BL, bit3 BR)
//   MODE_DYN   1 = dynamic path (DYNEN+DEN), 0 = static (SEN); sampled on ARM entry
//   ACK[3:0]   granted quadrant state
//   BUSY       FSM outside IDLE
//   SSEL       any quadrant has SEN or DYNEN set
//   <Q>_DEN/_DYNEN/_SEN/_VLP  per-quadrant mux controls
module gmux_qen_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int VLP_DELAY     = 16
) (
  input  logic       QCK,
  input  logic       QRT_N,
  input  logic [3:0] REQ_EN,
  input  logic       MODE_DYN,
  output logic [3:0] ACK,
  output logic       BUSY,
  output logic       SSEL,
  output logic       TL_DEN,
  output logic       TL_DYNEN,
  output logic       TL_SEN,
  output logic       TL_VLP,
  output logic       TR_DEN,
  output logic       TR_DYNEN,
  output logic       TR_SEN,
  output logic       TR_VLP,
  output logic       BL_DEN,
  output logic       BL_DYNEN,
  output logic       BL_SEN,
  output logic       BL_VLP,
  output logic       BR_DEN,
  output logic       BR_DYNEN,
  output logic       BR_SEN,
  output logic       BR_VLP
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gmux_qen_ctrl: SETTLE_CYCLES must be in 1..255");
  end
  if (VLP_DELAY < 1 || VLP_DELAY > 255) begin : g_bad_vlp
    $error("gmux_qen_ctrl: VLP_DELAY must be in 1..255");
  end

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] VLP_LD    = 8'(VLP_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAKE,
    S_ARM,
    S_DROP,
    S_SLEEP
  } state_t;

  state_t     state;
  logic [3:0] den, dynen, sen, vlp;
  logic [1:0] p, q;
  logic [7:0] cnt;
  logic       mode_l;
  logic [3:0] q_mask;

  assign q_mask = 4'b0001 << q;

  always_ff @(posedge QCK) begin
    if (!QRT_N) begin
      state  <= S_IDLE;
      den    <= '0;
      dynen  <= '0;
      sen    <= '0;
      vlp    <= '1;
      ACK    <= '0;
      BUSY   <= 1'b0;
      SSEL   <= 1'b0;
      p      <= '0;
      q      <= '0;
      cnt    <= '0;
      mode_l <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_EN[p] != ACK[p]) begin
            q    <= p;
            BUSY <= 1'b1;
            cnt  <= SETTLE_LD;
            if (REQ_EN[p]) begin
              state  <= S_WAKE;
              vlp[p] <= 1'b0;
            end else begin
              state  <= S_DROP;
              den[p] <= 1'b0;
            end
          end else begin
            p <= p + 2'd1;
          end
        end
        S_WAKE: begin
          if (cnt == 8'd0) begin
            state  <= S_ARM;
            mode_l <= MODE_DYN;
            if (MODE_DYN) dynen[q] <= 1'b1;
            else          sen[q]   <= 1'b1;
            SSEL   <= 1'b1;
            cnt    <= SETTLE_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_ARM: begin
          if (cnt == 8'd0) begin
            state  <= S_IDLE;
            BUSY   <= 1'b0;
            if (mode_l) den[q] <= 1'b1;
            ACK[q] <= 1'b1;
            p      <= q + 2'd1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_DROP: begin
          if (cnt == 8'd0) begin
            state    <= S_SLEEP;
            sen[q]   <= 1'b0;
            dynen[q] <= 1'b0;
            ACK[q]   <= 1'b0;
            cnt      <= VLP_LD;
            // SSEL follows the post-clear select set
            SSEL     <= |((sen | dynen) & ~q_mask);
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_SLEEP: begin
          if (REQ_EN[q]) begin
            // re-enable while sleeping: keep VLP low and rescan q first
            state <= S_IDLE;
            BUSY  <= 1'b0;
            p     <= q;
          end else if (cnt == 8'd0) begin
            state  <= S_IDLE;
            BUSY   <= 1'b0;
            vlp[q] <= 1'b1;
            p      <= q + 2'd1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  assign {BR_DEN,   BL_DEN,   TR_DEN,   TL_DEN}   = den;
  assign {BR_DYNEN, BL_DYNEN, TR_DYNEN, TL_DYNEN} = dynen;
  assign {BR_SEN,   BL_SEN,   TR_SEN,   TL_SEN}   = sen;
  assign {BR_VLP,   BL_VLP,   TR_VLP,   TL_VLP}   = vlp;

endmodule

// File: tb/tb_gmux_qen_ctrl.sv
// Scoreboarded bench for gmux_qen_ctrl. Stimulus pushes the expected ACK
// transitions; a monitor matches each observed ACK change against the queue
// and checks its timing relative to BUSY rising, plus per-cycle invariants.
module tb_gmux_qen_ctrl;
  localparam int N = 4;
  localparam int M = 16;

  logic       QCK = 1'b0;
  logic       QRT_N = 1'b0;
  logic [3:0] REQ_EN = 4'b0;
  logic       MODE_DYN = 1'b0;
  logic [3:0] ACK;
  logic       BUSY, SSEL;
  logic TL_DEN, TL_DYNEN, TL_SEN, TL_VLP, TR_DEN, TR_DYNEN, TR_SEN, TR_VLP;
  logic BL_DEN, BL_DYNEN, BL_SEN, BL_VLP, BR_DEN, BR_DYNEN, BR_SEN, BR_VLP;
  logic [3:0] den, dynen, sen, vlp;

  assign den   = {BR_DEN, BL_DEN, TR_DEN, TL_DEN};
  assign dynen = {BR_DYNEN, BL_DYNEN, TR_DYNEN, TL_DYNEN};
  assign sen   = {BR_SEN, BL_SEN, TR_SEN, TL_SEN};
  assign vlp   = {BR_VLP, BL_VLP, TR_VLP, TL_VLP};

  gmux_qen_ctrl #(.SETTLE_CYCLES(N), .VLP_DELAY(M)) dut (
    .QCK(QCK), .QRT_N(QRT_N), .REQ_EN(REQ_EN), .MODE_DYN(MODE_DYN),
    .ACK(ACK), .BUSY(BUSY), .SSEL(SSEL),
    .TL_DEN(TL_DEN), .TL_DYNEN(TL_DYNEN), .TL_SEN(TL_SEN), .TL_VLP(TL_VLP),
    .TR_DEN(TR_DEN), .TR_DYNEN(TR_DYNEN), .TR_SEN(TR_SEN), .TR_VLP(TR_VLP),
    .BL_DEN(BL_DEN), .BL_DYNEN(BL_DYNEN), .BL_SEN(BL_SEN), .BL_VLP(BL_VLP),
    .BR_DEN(BR_DEN), .BR_DYNEN(BR_DYNEN), .BR_SEN(BR_SEN), .BR_VLP(BR_VLP)
  );

  always #5 QCK = ~QCK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic       val;
    logic       dyn;
  } ev_t;
  ev_t exp_q[$];
  bit  mon_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic push_ev(int i, logic v, logic d);
    ev_t e;
    e.idx = 2'(i);
    e.val = v;
    e.dyn = d;
    exp_q.push_back(e);
  endtask

  // expected events for moving every quadrant from current ACK to target
  task automatic push_target(logic [3:0] tgt, logic d);
    for (int i = 0; i < 4; i++)
      if (tgt[i] != ACK[i]) push_ev(i, tgt[i], d);
  endtask

  task automatic wait_busy(string nm);
    int k = 0;
    while (!BUSY && k < 10) begin @(negedge QCK); k++; end
    chk(nm, 32'(BUSY), 32'd1);
  endtask

  task automatic wait_settled(string nm, int budget);
    int k = 0;
    while ((BUSY || ACK != REQ_EN) && k < budget) begin @(negedge QCK); k++; end
    chk(nm, 32'({BUSY, ACK}), 32'({1'b0, REQ_EN}));
  endtask

  task automatic check_reset_vals(string nm);
    chk({nm, "_vlp"}, 32'(vlp), 32'hF);
    chk({nm, "_ctl"}, 32'({den, dynen, sen}), 32'd0);
    chk({nm, "_ack"}, 32'(ACK), 32'd0);
    chk({nm, "_busy_ssel"}, 32'({BUSY, SSEL}), 32'd0);
  endtask

  // monitor: invariants every cycle, ACK transitions against the scoreboard
  initial begin
    logic [3:0] prev_ack = 4'b0;
    logic prev_busy = 1'b0;
    int cyc = 0, e0 = 0;
    forever begin
      @(negedge QCK);
      cyc++;
      if (BUSY && !prev_busy) e0 = cyc;
      if (mon_en) begin
        chk("inv_den_dynen", 32'(den & ~dynen), 32'd0);
        chk("inv_sen_dynen", 32'(sen & dynen), 32'd0);
        chk("inv_vlp_off", 32'(vlp & (sen | dynen | den)), 32'd0);
        chk("inv_ssel", 32'(SSEL), 32'(|(sen | dynen)));
        if (ACK != prev_ack) begin
          logic [3:0] diff;
          int idx, found;
          diff  = ACK ^ prev_ack;
          idx   = 0;
          found = -1;
          chk("ack_single_bit", $countones(diff), 1);
          for (int i = 0; i < 4; i++) if (diff[i]) idx = i;
          for (int i = 0; i < exp_q.size(); i++)
            if (found < 0 && exp_q[i].idx == 2'(idx) && exp_q[i].val == ACK[idx]) found = i;
          checks++;
          if (found < 0) begin
            errors++;
            $display("FAIL ack_unexpected act=%b exp_pending=%0d", ACK, exp_q.size());
          end else begin
            if (ACK[idx]) begin
              chk("ack_rise_time", cyc - e0, 2 * N);
              chk("ack_rise_mode", 32'({den[idx], dynen[idx], sen[idx]}),
                  32'({exp_q[found].dyn, exp_q[found].dyn, !exp_q[found].dyn}));
            end else begin
              chk("ack_fall_time", cyc - e0, N);
            end
            exp_q.delete(found);
          end
        end
      end
      prev_ack  = ACK;
      prev_busy = BUSY;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int got, last, ack_k;
    logic [3:0] pa, nt;

    // reset values
    QRT_N = 1'b0;
    repeat (2) @(negedge QCK);
    QRT_N = 1'b1;
    repeat (3) @(negedge QCK);
    check_reset_vals("reset");

    // dynamic enable of TL with the scan pointer at TL
    QRT_N = 1'b0; REQ_EN = 4'b0001; MODE_DYN = 1'b1;
    repeat (2) @(negedge QCK);
    QRT_N = 1'b1; mon_en = 1'b1;
    push_ev(0, 1'b1, 1'b1);
    wait_busy("en_tl_busy");
    chk("en_tl_vlp_e0", 32'(TL_VLP), 32'd0);
    seen = TL_SEN;
    for (int j = 1; j <= 2 * N; j++) begin
      @(negedge QCK);
      seen |= TL_SEN;
      if (j == N - 1) chk("en_tl_dynen_early", 32'(TL_DYNEN), 32'd0);
      if (j == N)     chk("en_tl_dynen_ssel", 32'({TL_DYNEN, SSEL}), 32'b11);
      if (j == 2 * N - 1) chk("en_tl_ack_early", 32'(ACK), 32'd0);
      if (j == 2 * N) chk("en_tl_den_ack", 32'({TL_DEN, ACK}), 32'b1_0001);
    end
    chk("en_tl_no_sen", 32'(seen), 32'd0);
    wait_settled("en_tl_settle", 50);

    // static enable of BR (TL released), then static disable of BR
    MODE_DYN = 1'b0;
    push_target(4'b1000, 1'b0);
    REQ_EN = 4'b1000;
    wait_settled("en_br_settle", 200);
    push_target(4'b0000, 1'b0);
    REQ_EN = 4'b0000;
    wait_busy("dis_br_busy");
    for (int j = 1; j <= N + M; j++) begin
      @(negedge QCK);
      if (j == N - 1) chk("dis_br_sen_early", 32'(BR_SEN), 32'd1);
      if (j == N) chk("dis_br_sen_ack_ssel", 32'({BR_SEN, ACK, SSEL}), 32'd0);
      if (j == N + M - 1) chk("dis_br_vlp_early", 32'({BR_VLP, BUSY}), 32'b01);
      if (j == N + M) chk("dis_br_vlp_busy", 32'({BR_VLP, BUSY}), 32'b10);
    end

    // abort: re-request TR three cycles into its VLP delay
    MODE_DYN = 1'b1;
    push_target(4'b0010, 1'b1);
    REQ_EN = 4'b0010;
    wait_settled("ab_en_settle", 200);
    push_target(4'b0000, 1'b1);
    REQ_EN = 4'b0000;
    wait_busy("ab_dis_busy");
    repeat (N + 3) @(negedge QCK);
    push_ev(1, 1'b1, 1'b1);
    REQ_EN = 4'b0010;
    seen = 1'b0; ack_k = 0;
    // k=1 is the cycle after the abort edge
    for (int k = 1; k <= 2 * N + 4; k++) begin
      @(negedge QCK);
      seen |= TR_VLP;
      if (ACK[1] && ack_k == 0) ack_k = k;
    end
    chk("ab_vlp_stays_low", 32'(seen), 32'd0);
    chk("ab_reack_time", ack_k, 2 * N + 2);
    push_target(4'b0000, 1'b1);
    REQ_EN = 4'b0000;
    wait_settled("ab_off_settle", 200);

    // simultaneous requests out of reset: TL, TR, BL, BR in order
    QRT_N = 1'b0; mon_en = 1'b0;
    repeat (2) @(negedge QCK);
    exp_q.delete();
    QRT_N = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 4; i++) push_ev(i, 1'b1, 1'b1);
    REQ_EN = 4'b1111;
    got = 0; last = 0; pa = ACK;
    for (int k = 0; k < 60 && got < 4; k++) begin
      @(negedge QCK);
      if (ACK != pa) begin
        chk("sim_order", 32'(ACK ^ pa), 32'd1 << got);
        if (got > 0) chk("sim_spacing", k - last, 2 * N + 1);
        last = k; got++; pa = ACK;
      end
    end
    chk("sim_count", got, 4);
    wait_settled("sim_settle", 50);

    // reset in the middle of BL's ARM step, then restart BL
    QRT_N = 1'b0; mon_en = 1'b0;
    repeat (2) @(negedge QCK);
    exp_q.delete();
    REQ_EN = 4'b0100;
    QRT_N = 1'b1;
    wait_busy("rarm_busy");
    repeat (N + 1) @(negedge QCK);
    chk("rarm_in_arm", 32'({BL_DYNEN, ACK[2]}), 32'b10);
    QRT_N = 1'b0;
    @(negedge QCK);
    check_reset_vals("rarm_reset");
    QRT_N = 1'b1; mon_en = 1'b1;
    push_ev(2, 1'b1, 1'b1);
    wait_busy("rarm_restart_busy");
    chk("rarm_restart_wake", 32'({BL_VLP, BL_DYNEN, BL_SEN}), 32'd0);
    wait_settled("rarm_settle", 50);

    // randomized targets against the scoreboard
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 5)) @(negedge QCK);
      MODE_DYN = 1'($urandom_range(0, 1));
      nt = 4'($urandom_range(0, 15));
      push_target(nt, MODE_DYN);
      REQ_EN = nt;
      wait_settled("rnd_settle", 300);
    end

    repeat (3) @(negedge QCK);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
